// File: rtl/filter_buffer_ctrl.sv
// filter_buffer_ctrl: ping-pong filter buffer between the DRAM filter loader and the PE engine.
// One bank is filled through a valid/ready stream while the other serves one-cycle-latency reads.
// Optional build macro FB_STALL_CNT_EN adds o_stall_cnt, a saturating count of cycles the PE
// waits on a read bank that is being filled.
module filter_buffer_ctrl #(
  parameter int unsigned FILTER_DW     = 72,
  parameter int unsigned FILTER_BUF_AW = 8,
  parameter int unsigned NB_LANE       = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             i_ld_start,
  input  logic [FILTER_BUF_AW:0]           i_ld_words,
  input  logic                             i_ld_vld,
  input  logic [NB_LANE*FILTER_DW-1:0]     i_ld_data,
  output logic                             o_ld_rdy,
  output logic                             o_ld_done,
  input  logic                             i_fb_req,
  input  logic [FILTER_BUF_AW-1:0]         i_fb_addr,
  output logic                             o_fb_req_possible,
  output logic [FILTER_DW-1:0]             o_fb_data0,
  output logic [FILTER_DW-1:0]             o_fb_data1,
  output logic [FILTER_DW-1:0]             o_fb_data2,
  output logic [FILTER_DW-1:0]             o_fb_data3,
  input  logic                             i_rd_release,
  output logic [1:0]                       o_bank_full,
  output logic                             o_err
`ifdef FB_STALL_CNT_EN
  ,
  output logic [31:0]                      o_stall_cnt
`endif
);

  localparam int unsigned WORD_W = NB_LANE * FILTER_DW;
  localparam int unsigned DEPTH  = 2 ** FILTER_BUF_AW;
  localparam int unsigned CW     = FILTER_BUF_AW + 1;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_st_e;

  bank_st_e                 bank_st     [2];
  bank_st_e                 bank_st_nxt [2];
  logic [CW-1:0]            bank_words  [2];
  logic                     wr_bank;
  logic                     rd_bank;
  logic                     wr_bank_nxt;
  logic                     rd_bank_nxt;
  logic [FILTER_BUF_AW-1:0] wr_cnt;
  logic [FILTER_BUF_AW-1:0] last_idx;
  logic [WORD_W-1:0]        rd_data;

  // Both banks live in one array; the bank pointer is the address MSB
  logic [WORD_W-1:0]        mem [2*DEPTH];

  logic words_ok;
  logic start_ok;
  logic start_bad;
  logic beat;
  logic last_beat;
  logic rd_full;
  logic addr_ok;
  logic rd_hit;
  logic rd_bad;
  logic rel_ok;
  logic rel_bad;

  // Event decode against pre-edge state and next bank states
  always_comb begin
    words_ok  = (i_ld_words != '0) && (i_ld_words <= CW'(DEPTH));
    start_ok  = i_ld_start && (bank_st[wr_bank] == BANK_EMPTY) && words_ok;
    start_bad = i_ld_start && !start_ok;
    last_idx  = FILTER_BUF_AW'(bank_words[wr_bank] - CW'(1));
    beat      = i_ld_vld && o_ld_rdy;
    last_beat = beat && (wr_cnt == last_idx);
    rd_full   = (bank_st[rd_bank] == BANK_FULL);
    addr_ok   = (CW'(i_fb_addr) < bank_words[rd_bank]);
    rd_hit    = i_fb_req && rd_full && addr_ok;
    rd_bad    = i_fb_req && !rd_hit;
    rel_ok    = i_rd_release && rd_full;
    rel_bad   = i_rd_release && !rd_full;

    for (int b = 0; b < 2; b++) begin
      bank_st_nxt[b] = bank_st[b];
    end
    // start needs EMPTY, last beat needs FILLING, release needs FULL: never the same bank twice
    if (start_ok)  bank_st_nxt[wr_bank] = BANK_FILLING;
    if (last_beat) bank_st_nxt[wr_bank] = BANK_FULL;
    if (rel_ok)    bank_st_nxt[rd_bank] = BANK_EMPTY;

    wr_bank_nxt = wr_bank ^ last_beat;
    rd_bank_nxt = rd_bank ^ rel_ok;
  end

  // Bank state, pointers, counters and registered status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_st[0]        <= BANK_EMPTY;
      bank_st[1]        <= BANK_EMPTY;
      bank_words[0]     <= '0;
      bank_words[1]     <= '0;
      wr_bank           <= 1'b0;
      rd_bank           <= 1'b0;
      wr_cnt            <= '0;
      o_ld_rdy          <= 1'b0;
      o_ld_done         <= 1'b0;
      o_fb_req_possible <= 1'b0;
      o_bank_full       <= 2'b00;
      o_err             <= 1'b0;
    end else begin
      bank_st[0]        <= bank_st_nxt[0];
      bank_st[1]        <= bank_st_nxt[1];
      wr_bank           <= wr_bank_nxt;
      rd_bank           <= rd_bank_nxt;
      if (start_ok) begin
        bank_words[wr_bank] <= i_ld_words;
        wr_cnt              <= '0;
      end else if (beat) begin
        wr_cnt <= wr_cnt + FILTER_BUF_AW'(1);
      end
      o_ld_rdy          <= (bank_st_nxt[wr_bank_nxt] == BANK_FILLING);
      o_ld_done         <= last_beat;
      o_fb_req_possible <= (bank_st_nxt[rd_bank_nxt] == BANK_FULL);
      o_bank_full       <= {bank_st_nxt[1] == BANK_FULL, bank_st_nxt[0] == BANK_FULL};
      if (start_bad || rd_bad || rel_bad) o_err <= 1'b1;
    end
  end

  // Loader write port
  always_ff @(posedge clk) begin
    if (beat) mem[{wr_bank, wr_cnt}] <= i_ld_data;
  end

  // PE read port: one-cycle latency, zero on a bad request, hold when idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (i_fb_req) begin
      rd_data <= rd_hit ? mem[{rd_bank, i_fb_addr}] : '0;
    end
  end

  assign o_fb_data0 = rd_data[0*FILTER_DW +: FILTER_DW];
  assign o_fb_data1 = rd_data[1*FILTER_DW +: FILTER_DW];
  assign o_fb_data2 = rd_data[2*FILTER_DW +: FILTER_DW];
  assign o_fb_data3 = rd_data[3*FILTER_DW +: FILTER_DW];

`ifdef FB_STALL_CNT_EN
  // Saturating count of cycles the read bank is claimed but not yet full
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_stall_cnt <= '0;
    end else if (!o_fb_req_possible && (bank_st[rd_bank] != BANK_EMPTY) && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
